abus_burst_gen: RTL and testbench
=================================

Name: abus_burst_gen

Overview:
- Address-bus initiator for the ABUS path: issues a sequence of phrase addresses with a strobe.
- The wide AND/NAND match decoders on the responder side decode each address and return an acknowledge.
- Latches a start address and beat count, steps the address per acknowledged beat, and pulses completion or timeout-error status back to the requesting unit.

Parameters:
- AW, 24, address width in bits.
- LW, 3, beat-count width; legal bursts are 1..2^LW-1 beats.
- STEP, 8, byte increment per beat; power of two; log2(STEP) low address bits are forced to 0.
- TW, 4, timeout counter width; a beat aborts after 2^TW-1 strobe cycles without acknowledge.

Ports:
- sys_clk  in  1  system clock, all state on rising edge.
- resetl  in  1  asynchronous active-low reset.
- req  in  1  start request, sampled only in IDLE.
- start_addr  in  AW  first beat address.
- burst_len  in  LW  beat count; 0 = no-op.
- rd  in  1  direction latched with request: 1 = read, 0 = write.
- busy  out  1  high from the edge accepting req until the edge leaving DRIVE.
- done  out  1  one-cycle pulse after the final beat is acknowledged.
- err  out  1  one-cycle pulse after a timeout abort.
- abus_addr  out  AW  current beat address.
- abus_strobe  out  1  address valid / beat request.
- abus_read  out  1  latched direction, valid while abus_strobe is high.
- abus_ack  in  1  responder acknowledge, sampled only while abus_strobe is high.

Behaviour:
- Reset values (asynchronous, resetl low): state=IDLE; busy, done, err, abus_strobe, abus_read = 0; abus_addr = 0; counters = 0.
- Reset mid-burst aborts immediately; no done or err pulse is produced.

States:
- IDLE: on req=1 and burst_len!=0 at edge N:
  - latch addr = start_addr with low log2(STEP) bits cleared; cnt = burst_len; abus_read = rd; go to DRIVE.
  - abus_strobe, busy and abus_addr are valid in cycle N+1 (one-edge latency).
  - req with burst_len=0 is ignored: no busy, no pulse.
- DRIVE: abus_strobe=1.
  - ack=1 and cnt==1: go to DONE; strobe drops at the same edge.
  - ack=1 and cnt>1: cnt-1; addr+STEP modulo 2^AW (wrap FFFFF8->000000 for AW=24, STEP=8); stay in DRIVE. Back-to-back beats give one beat per cycle and strobe stays high.
  - ack=0: timeout counter +1. When it reaches 2^TW-1, go to ERR; strobe drops.
  - Timeout counter clears on every acknowledged beat and on entry to DRIVE.
- DONE: done=1 for exactly one cycle, then IDLE.
- ERR: err=1 for exactly one cycle, then IDLE.

Rules:
- A new req is accepted only in IDLE. req asserted in DONE or ERR is ignored; the requester re-asserts.
- A req held high continuously starts a new burst on the first IDLE cycle.
- done and err are mutually exclusive.
- busy = (state==DRIVE).
- ack in the same cycle the timeout terminal count is reached counts as acknowledged; the ack takes priority.
- abus_ack outside DRIVE is ignored.
- abus_addr holds its last value after a burst; it is not cleared.
- start_addr, burst_len and rd changing during a burst have no effect.

Decomposition:
- Shared defs package holds:
  - the state encoding constants (IDLE, DRIVE, DONE, ERR), 2 bits;
  - AW/STEP defaults shared with the ABUS decoders.
- One natural sub-module, abus_beat_timer: TW-bit counter with clear, enable and terminal-count output; also reusable by other ABUS initiators.
- The rest (FSM, address/count registers) stays flat in abus_burst_gen.

Test Plan:
- Reset/idle: hold resetl=0, then release with no req -> all outputs 0 for 20 cycles; abus_ack pulses are ignored.
- Single beat: req, start_addr=0x12345F, len=1, rd=1, ack one cycle after strobe rises -> abus_addr=0x123458, abus_read=1, strobe high 2 cycles, done pulses once the next cycle, busy falls with strobe.
- Four-beat back-to-back: start=0x000100, len=4, ack held high -> addresses 0x100, 0x108, 0x110, 0x118 on consecutive cycles, then one done pulse; no err.
- Wrap plus wait states: start=0xFFFFF0, len=3, ack every 3rd cycle -> addresses 0xFFFFF0, 0xFFFFF8, 0x000000; each held until acked; done pulses.
- Timeout: len=2, ack never -> strobe high 15 cycles (TW=4), then err pulses once, no done; a second case with ack arriving exactly on the 15th cycle -> beat accepted, no err.
- Corner cases:
  - len=0 req -> nothing happens.
  - req during DRIVE -> ignored.
  - resetl low mid-burst -> strobe drops asynchronously, no pulse, and the next req starts cleanly.

Source files
------------

// File: rtl/abus_burst_gen_pkg.sv
// Shared ABUS definitions.
//   - Default address width and beat stride, common to the burst initiator
//     and the responder-side match decoders.
//   - Burst initiator state encoding (2 bits).
package abus_burst_gen_pkg;

  localparam int ABUS_AW   = 24;
  localparam int ABUS_STEP = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2,
    ERR   = 2'd3
  } burst_state_t;

endpackage

// File: rtl/abus_beat_timer.sv
// Per-beat wait-state timer for ABUS initiators.
// Counts cycles in which a beat is outstanding without acknowledge.
//   sys_clk : clock, rising edge
//   resetl  : asynchronous active-low reset
//   clr     : synchronous clear (wins over en)
//   en      : count one more unacknowledged cycle
//   tc      : high on the cycle whose increment reaches 2^TW-1, so the
//             owner can abort on that same edge
module abus_beat_timer #(
  parameter int TW = 4
) (
  input  logic sys_clk,
  input  logic resetl,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [TW-1:0] LAST = TW'((2 ** TW) - 2);

  logic [TW-1:0] cnt;

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TW'(1);
    end
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/abus_burst_gen.sv
// ABUS burst address initiator.
// Latches a start address and beat count, presents one phrase address per
// beat with a strobe, steps the address on each acknowledged beat, and
// reports completion (done) or a per-beat timeout abort (err).
//   sys_clk     : clock, rising edge
//   resetl      : asynchronous active-low reset
//   req         : start request, only looked at in IDLE
//   start_addr  : first beat address (low log2(STEP) bits ignored)
//   burst_len   : number of beats, 0 = no-op
//   rd          : direction captured with the request (1 = read)
//   busy        : burst in progress (DRIVE)
//   done        : one-cycle pulse after the last beat is acknowledged
//   err         : one-cycle pulse after a timeout abort
//   abus_addr   : current beat address, holds after the burst
//   abus_strobe : beat request / address valid
//   abus_read   : captured direction
//   abus_ack    : responder acknowledge, only looked at in DRIVE
module abus_burst_gen
  import abus_burst_gen_pkg::*;
#(
  parameter int AW   = ABUS_AW,
  parameter int LW   = 3,
  parameter int STEP = ABUS_STEP,
  parameter int TW   = 4
) (
  input  logic          sys_clk,
  input  logic          resetl,
  input  logic          req,
  input  logic [AW-1:0] start_addr,
  input  logic [LW-1:0] burst_len,
  input  logic          rd,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] abus_addr,
  output logic          abus_strobe,
  output logic          abus_read,
  input  logic          abus_ack
);

  localparam logic [AW-1:0] LOW_MASK = AW'(STEP - 1);
  localparam logic [AW-1:0] STEP_INC = AW'(STEP);

  burst_state_t  state;
  burst_state_t  state_nxt;
  logic [LW-1:0] cnt;
  logic          accept;
  logic          beat_ack;
  logic          last_beat;
  logic          tmr_clr;
  logic          tmr_en;
  logic          tmr_tc;

  function automatic logic [AW-1:0] align_addr(input logic [AW-1:0] a);
    return a & ~LOW_MASK;
  endfunction

  assign accept    = (state == IDLE) && req && (burst_len != '0);
  assign beat_ack  = (state == DRIVE) && abus_ack;
  assign last_beat = (cnt == LW'(1));

  // The timer only runs while a beat is outstanding; any ack or any
  // non-DRIVE cycle restarts it, so each beat gets the full window.
  assign tmr_clr = (state != DRIVE) || abus_ack;
  assign tmr_en  = (state == DRIVE) && !abus_ack;

  abus_beat_timer #(
    .TW(TW)
  ) u_timer (
    .sys_clk (sys_clk),
    .resetl  (resetl),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .tc      (tmr_tc)
  );

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // An ack on the terminal-count cycle is checked first, so it is honoured.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = DRIVE;
      end
      DRIVE: begin
        if (abus_ack) begin
          if (last_beat) state_nxt = DONE;
        end else if (tmr_tc) begin
          state_nxt = ERR;
        end
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The final acknowledged beat leaves the address in place so it stays
  // visible after the burst.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      abus_addr <= '0;
      cnt       <= '0;
      abus_read <= 1'b0;
    end else if (accept) begin
      abus_addr <= align_addr(start_addr);
      cnt       <= burst_len;
      abus_read <= rd;
    end else if (beat_ack && !last_beat) begin
      abus_addr <= abus_addr + STEP_INC;
      cnt       <= cnt - LW'(1);
    end
  end

  assign busy        = (state == DRIVE);
  assign abus_strobe = (state == DRIVE);
  assign done        = (state == DONE);
  assign err         = (state == ERR);

endmodule

// File: tb/tb_abus_burst_gen.sv
module tb_abus_burst_gen;

  logic        sys_clk;
  logic        resetl;
  logic        req;
  logic [23:0] start_addr;
  logic [2:0]  burst_len;
  logic        rd;
  logic        busy;
  logic        done;
  logic        err;
  logic [23:0] abus_addr;
  logic        abus_strobe;
  logic        abus_read;
  logic        abus_ack;

  int errors = 0;
  int checks = 0;

  abus_burst_gen dut (
    .sys_clk     (sys_clk),
    .resetl      (resetl),
    .req         (req),
    .start_addr  (start_addr),
    .burst_len   (burst_len),
    .rd          (rd),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .abus_addr   (abus_addr),
    .abus_strobe (abus_strobe),
    .abus_read   (abus_read),
    .abus_ack    (abus_ack)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        req;
    logic [23:0] sa;
    logic [2:0]  len;
    logic        rd;
    logic        ack;
    logic        st;
    logic        bz;
    logic        dn;
    logic        er;
    logic [23:0] addr;
    logic        rdo;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rq, input logic [23:0] sa, input logic [2:0] len,
                     input logic r, input logic ak, input logic st, input logic bz,
                     input logic dn, input logic er, input logic [23:0] ad,
                     input logic rdo);
    vec_t v;
    v.req = rq; v.sa = sa; v.len = len; v.rd = r; v.ack = ak;
    v.st = st; v.bz = bz; v.dn = dn; v.er = er; v.addr = ad; v.rdo = rdo;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // {strobe, busy, done, err, read, addr}
  function automatic logic [31:0] outs();
    return {3'b0, abus_strobe, busy, done, err, abus_read, abus_addr};
  endfunction

  function automatic logic [31:0] pack(input logic st, input logic bz, input logic dn,
                                       input logic er, input logic rdo, input logic [23:0] a);
    return {3'b0, st, bz, dn, er, rdo, a};
  endfunction

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin : main
    int n;
    int err_seen;
    resetl = 1'b0; req = 1'b0; start_addr = '0; burst_len = '0; rd = 1'b0; abus_ack = 1'b0;

    // Single beat, ack one cycle after strobe rises, address aligned.
    add(1, 24'h12345F, 3'd1, 1, 0,  0, 0, 0, 0, 24'h000000, 0);
    add(0, 24'h0,      3'd0, 0, 0,  1, 1, 0, 0, 24'h123458, 1);
    add(0, 24'h0,      3'd0, 0, 1,  1, 1, 0, 0, 24'h123458, 1);
    add(0, 24'h0,      3'd0, 0, 0,  0, 0, 1, 0, 24'h123458, 1);
    add(0, 24'h0,      3'd0, 0, 0,  0, 0, 0, 0, 24'h123458, 1);
    // Four beats back-to-back; ack high in IDLE is ignored, req in DRIVE and DONE ignored.
    add(1, 24'h000100, 3'd4, 0, 1,  0, 0, 0, 0, 24'h123458, 1);
    add(0, 24'h0,      3'd0, 0, 1,  1, 1, 0, 0, 24'h000100, 0);
    add(1, 24'hABCDE0, 3'd5, 1, 1,  1, 1, 0, 0, 24'h000108, 0);
    add(1, 24'hABCDE0, 3'd5, 1, 1,  1, 1, 0, 0, 24'h000110, 0);
    add(0, 24'h0,      3'd0, 0, 1,  1, 1, 0, 0, 24'h000118, 0);
    add(1, 24'h000700, 3'd2, 1, 0,  0, 0, 1, 0, 24'h000118, 0);
    add(0, 24'h0,      3'd0, 0, 0,  0, 0, 0, 0, 24'h000118, 0);
    add(0, 24'h0,      3'd0, 0, 0,  0, 0, 0, 0, 24'h000118, 0);
    // Zero-length request is a no-op.
    add(1, 24'h555555, 3'd0, 1, 0,  0, 0, 0, 0, 24'h000118, 0);
    add(0, 24'h0,      3'd0, 0, 0,  0, 0, 0, 0, 24'h000118, 0);
    // Wrap with two wait states per beat.
    add(1, 24'hFFFFF0, 3'd3, 1, 0,  0, 0, 0, 0, 24'h000118, 0);
    add(0, 24'h0,      3'd0, 0, 0,  1, 1, 0, 0, 24'hFFFFF0, 1);
    add(0, 24'h0,      3'd0, 0, 0,  1, 1, 0, 0, 24'hFFFFF0, 1);
    add(0, 24'h0,      3'd0, 0, 1,  1, 1, 0, 0, 24'hFFFFF0, 1);
    add(0, 24'h0,      3'd0, 0, 0,  1, 1, 0, 0, 24'hFFFFF8, 1);
    add(0, 24'h0,      3'd0, 0, 0,  1, 1, 0, 0, 24'hFFFFF8, 1);
    add(0, 24'h0,      3'd0, 0, 1,  1, 1, 0, 0, 24'hFFFFF8, 1);
    add(0, 24'h0,      3'd0, 0, 0,  1, 1, 0, 0, 24'h000000, 1);
    add(0, 24'h0,      3'd0, 0, 0,  1, 1, 0, 0, 24'h000000, 1);
    add(0, 24'h0,      3'd0, 0, 1,  1, 1, 0, 0, 24'h000000, 1);
    add(0, 24'h0,      3'd0, 0, 0,  0, 0, 1, 0, 24'h000000, 1);
    add(0, 24'h0,      3'd0, 0, 0,  0, 0, 0, 0, 24'h000000, 1);

    // Reset state, then 20 idle cycles with ack toggling.
    repeat (3) step();
    chk("reset_outputs", outs(), pack(0, 0, 0, 0, 0, 24'h0));
    resetl = 1'b1;
    for (int i = 0; i < 20; i++) begin
      abus_ack = i[0];
      chk($sformatf("idle[%0d]", i), outs(), pack(0, 0, 0, 0, 0, 24'h0));
      step();
    end
    abus_ack = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      req = vecs[i].req; start_addr = vecs[i].sa; burst_len = vecs[i].len;
      rd = vecs[i].rd; abus_ack = vecs[i].ack;
      chk($sformatf("vec[%0d]", i), outs(),
          pack(vecs[i].st, vecs[i].bz, vecs[i].dn, vecs[i].er, vecs[i].rdo, vecs[i].addr));
      step();
    end

    // Timeout: two beats, never acked.
    req = 1'b1; start_addr = 24'h000040; burst_len = 3'd2; rd = 1'b0; abus_ack = 1'b0;
    step();
    req = 1'b0;
    n = 0; err_seen = 0;
    while (abus_strobe && n < 40) begin
      n++;
      if (done || err) err_seen++;
      step();
    end
    chk("timeout_strobe_cycles", 32'(n), 32'd15);
    chk("timeout_no_pulse_during", 32'(err_seen), 32'd0);
    chk("timeout_err_pulse", outs(), pack(0, 0, 0, 1, 0, 24'h000040));
    step();
    chk("timeout_err_one_cycle", outs(), pack(0, 0, 0, 0, 0, 24'h000040));

    // Ack exactly on the 15th strobe cycle wins over the timeout.
    req = 1'b1; start_addr = 24'h000200; burst_len = 3'd2; rd = 1'b1;
    step();
    req = 1'b0;
    n = 0;
    for (int i = 1; i <= 14; i++) begin
      if (abus_strobe && abus_addr == 24'h000200 && !err) n++;
      step();
    end
    chk("late_ack_wait14", 32'(n), 32'd14);
    abus_ack = 1'b1;
    chk("late_ack_cycle15", outs(), pack(1, 1, 0, 0, 1, 24'h000200));
    step();
    chk("late_ack_second_beat", outs(), pack(1, 1, 0, 0, 1, 24'h000208));
    step();
    abus_ack = 1'b0;
    chk("late_ack_done", outs(), pack(0, 0, 1, 0, 1, 24'h000208));
    step();

    // Asynchronous reset in the middle of a burst.
    req = 1'b1; start_addr = 24'h000400; burst_len = 3'd5; rd = 1'b1;
    step();
    req = 1'b0;
    step();
    chk("midburst_driving", outs(), pack(1, 1, 0, 0, 1, 24'h000400));
    resetl = 1'b0;
    #1;
    chk("midburst_async_drop", outs(), pack(0, 0, 0, 0, 0, 24'h0));
    step();
    resetl = 1'b1;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (done || err || abus_strobe || busy) n++;
      step();
    end
    chk("after_reset_quiet", 32'(n), 32'd0);
    req = 1'b1; start_addr = 24'h000307; burst_len = 3'd1; rd = 1'b0;
    step();
    req = 1'b0; abus_ack = 1'b1;
    chk("restart_beat", outs(), pack(1, 1, 0, 0, 0, 24'h000300));
    step();
    abus_ack = 1'b0;
    chk("restart_done", outs(), pack(0, 0, 1, 0, 0, 24'h000300));
    step();
    chk("restart_idle", outs(), pack(0, 0, 0, 0, 0, 24'h000300));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
